// File: rtl/uart_pkg.sv
// Shared definitions for the UART command path: state encoding, default widths
// and the result-byte-count helper. Honours the optional CHECKSUM_EN macro.
package uart_pkg;

    localparam int DEFAULT_N_BITS = 8;

`ifdef CHECKSUM_EN
    localparam int CHK_BYTES = 1;
    typedef enum logic [2:0] {
        IDLE, RX_A, RX_B, RX_OP, LATCH, TX_SEND, TX_WAIT, RX_CHK
    } state_t;
`else
    localparam int CHK_BYTES = 0;
    typedef enum logic [2:0] {
        IDLE, RX_A, RX_B, RX_OP, LATCH, TX_SEND, TX_WAIT
    } state_t;
`endif

    // Bytes sent back per frame: the result word plus an optional checksum byte.
    function automatic int res_bytes(input int data_bytes);
        return data_bytes + CHK_BYTES;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter for UART frame parsers: counts while run is high,
// restarts on clear, and pulses expire on the cycle the count reaches LIMIT.
module uart_frame_timer #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt;

    // A clear in the expiry cycle wins, so a late byte still counts as on time.
    assign expire = (LIMIT != 0) && run && !clear && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!run || clear || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_engine.sv
// Assembles A/B/OP from uart_rx, captures the ALU result and streams it to uart_tx.
// Optional CHECKSUM_EN adds an XOR check byte on receive and on transmit.
module uart_cmd_engine
    import uart_pkg::*;
#(
    parameter int N_BITS         = DEFAULT_N_BITS,
    parameter int DATA_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_BITS-1:0]            i_rx_data,
    input  logic                         i_rx_valid,
    output logic [N_BITS*DATA_BYTES-1:0] o_A,
    output logic [N_BITS*DATA_BYTES-1:0] o_B,
    output logic [N_BITS-1:0]            o_OP,
    input  logic [N_BITS*DATA_BYTES-1:0] i_res,
    output logic [N_BITS-1:0]            o_tx_data,
    output logic                         o_tx_start,
    input  logic                         i_tx_done,
    output logic                         o_busy,
    output logic                         o_frame_err,
    output logic                         o_overrun
);

    localparam int W         = N_BITS * DATA_BYTES;
    localparam int RES_BYTES = res_bytes(DATA_BYTES);
    localparam int IDX_W     = $clog2(RES_BYTES + 1);
    localparam logic [IDX_W-1:0] OPND_LAST = IDX_W'(DATA_BYTES - 1);
    localparam logic [IDX_W-1:0] RES_LAST  = IDX_W'(RES_BYTES - 1);

    state_t                      state, next_state;
    logic [IDX_W-1:0]            idx;
    logic [W-1:0]                a_shadow, b_shadow, a_ins, b_ins;
    logic [RES_BYTES*N_BITS-1:0] res_reg, res_full;
    logic [N_BITS-1:0]           tx_byte;
    logic                        timer_run, timeout, err_pulse, ovr_pulse;
`ifdef CHECKSUM_EN
    logic [N_BITS-1:0]           chk_acc, op_shadow, res_chk;
`endif

    uart_frame_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (timer_run),
        .clear  (i_rx_valid),
        .expire (timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        err_pulse  = 1'b0;
        ovr_pulse  = 1'b0;
        timer_run  = 1'b0;
        case (state)
            IDLE:    if (i_rx_valid) next_state = (DATA_BYTES == 1) ? RX_B : RX_A;
            RX_A: begin
                timer_run = 1'b1;
                if (i_rx_valid && idx == OPND_LAST) next_state = RX_B;
            end
            RX_B: begin
                timer_run = 1'b1;
                if (i_rx_valid && idx == OPND_LAST) next_state = RX_OP;
            end
            RX_OP: begin
                timer_run = 1'b1;
`ifdef CHECKSUM_EN
                if (i_rx_valid) next_state = RX_CHK;
            end
            RX_CHK: begin
                timer_run = 1'b1;
                if (i_rx_valid) begin
                    if (chk_acc == i_rx_data) begin
                        next_state = LATCH;
                    end else begin
                        err_pulse  = 1'b1;
                        next_state = IDLE;
                    end
                end
`else
                if (i_rx_valid) next_state = LATCH;
`endif
            end
            LATCH: begin
                ovr_pulse  = i_rx_valid;
                next_state = TX_SEND;
            end
            TX_SEND: begin
                ovr_pulse  = i_rx_valid;
                next_state = TX_WAIT;
            end
            TX_WAIT: begin
                ovr_pulse = i_rx_valid;
                if (i_tx_done) next_state = (idx == RES_LAST) ? IDLE : TX_SEND;
            end
            default: next_state = IDLE;
        endcase
        // The timer never expires in a cycle that carries a byte.
        if (timeout) begin
            err_pulse  = 1'b1;
            next_state = IDLE;
        end
    end

    // Byte insertion, result packing and transmit byte selection.
    always_comb begin
        a_ins   = a_shadow;
        b_ins   = b_shadow;
        tx_byte = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                a_ins[i*N_BITS +: N_BITS] = i_rx_data;
                b_ins[i*N_BITS +: N_BITS] = i_rx_data;
            end
        end
        for (int i = 0; i < RES_BYTES; i++) begin
            if (idx == IDX_W'(i)) tx_byte = res_reg[i*N_BITS +: N_BITS];
        end
`ifdef CHECKSUM_EN
        res_chk = '0;
        for (int i = 0; i < DATA_BYTES; i++) res_chk = res_chk ^ i_res[i*N_BITS +: N_BITS];
        res_full = {res_chk, i_res};
`else
        res_full = i_res;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            a_shadow    <= '0;
            b_shadow    <= '0;
            res_reg     <= '0;
            o_A         <= '0;
            o_B         <= '0;
            o_OP        <= '0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef CHECKSUM_EN
            chk_acc     <= '0;
            op_shadow   <= '0;
`endif
        end else begin
            o_tx_start  <= 1'b0;
            o_frame_err <= err_pulse;
            o_overrun   <= ovr_pulse;
            o_busy      <= (next_state != IDLE);
            case (state)
                IDLE, RX_A: if (i_rx_valid) begin
                    a_shadow <= a_ins;
                    if (idx == OPND_LAST) begin
                        o_A <= a_ins;
                        idx <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RX_B: if (i_rx_valid) begin
                    b_shadow <= b_ins;
                    if (idx == OPND_LAST) begin
                        o_B <= b_ins;
                        idx <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
`ifdef CHECKSUM_EN
                RX_OP:   if (i_rx_valid) op_shadow <= i_rx_data;
                RX_CHK:  if (i_rx_valid && chk_acc == i_rx_data) o_OP <= op_shadow;
`else
                RX_OP:   if (i_rx_valid) o_OP <= i_rx_data;
`endif
                LATCH: begin
                    res_reg <= res_full;
                    idx     <= '0;
                end
                TX_SEND: begin
                    o_tx_data  <= tx_byte;
                    o_tx_start <= 1'b1;
                end
                TX_WAIT: if (i_tx_done) idx <= (idx == RES_LAST) ? '0 : idx + 1'b1;
                default: ;
            endcase
`ifdef CHECKSUM_EN
            if (i_rx_valid) begin
                if (state == IDLE) chk_acc <= i_rx_data;
                else if (state == RX_A || state == RX_B || state == RX_OP)
                    chk_acc <= chk_acc ^ i_rx_data;
            end
`endif
            if (timeout) idx <= '0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed self-checking bench for uart_cmd_engine (default build, CHECKSUM_EN undefined)
// with an adding ALU mock and a 50-cycle inter-byte timeout.
module tb_uart_cmd_engine;

   logic        clk;
   logic        reset;
   logic [7:0]  rxData;
   logic        rxValid;
   logic [15:0] opA;
   logic [15:0] opB;
   logic [7:0]  opCode;
   logic [15:0] aluRes;
   logic [7:0]  txData;
   logic        txStart;
   logic        txDone;
   logic        busy;
   logic        frameErr;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   uart_cmd_engine #(
      .N_BITS         (8),
      .DATA_BYTES     (2),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_rx_data   (rxData),
      .i_rx_valid  (rxValid),
      .o_A         (opA),
      .o_B         (opB),
      .o_OP        (opCode),
      .i_res       (aluRes),
      .o_tx_data   (txData),
      .o_tx_start  (txStart),
      .i_tx_done   (txDone),
      .o_busy      (busy),
      .o_frame_err (frameErr),
      .o_overrun   (overrun)
   );

   // Combinational ALU stand-in: 16-bit add.
   assign aluRes = opA + opB;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      rxData  = b;
      rxValid = 1'b1;
      step();
      rxValid = 1'b0;
   endtask

   task automatic pulseTxDone();
      txDone = 1'b1;
      step();
      txDone = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic sendFrame(input logic [7:0] a0, a1, b0, b1, op);
      applyStimulus(a0);
      applyStimulus(a1);
      applyStimulus(b0);
      applyStimulus(b1);
      applyStimulus(op);
   endtask

   initial begin
      reset   = 1'b0;
      rxData  = 8'h00;
      rxValid = 1'b0;
      txDone  = 1'b0;
      step();
      step();
      checkOutput("rst_A",        32'(opA),      32'h0);
      checkOutput("rst_B",        32'(opB),      32'h0);
      checkOutput("rst_OP",       32'(opCode),   32'h0);
      checkOutput("rst_tx_data",  32'(txData),   32'h0);
      checkOutput("rst_tx_start", 32'(txStart),  32'h0);
      checkOutput("rst_busy",     32'(busy),     32'h0);
      checkOutput("rst_err",      32'(frameErr), 32'h0);
      checkOutput("rst_ovr",      32'(overrun),  32'h0);
      reset = 1'b1;
      step();

      // Basic frame: 0x1234 + 0x0101 = 0x1335, sent LSB first.
      applyStimulus(8'h34);
      checkOutput("f1_busy_first",  32'(busy), 32'h1);
      checkOutput("f1_A_partial",   32'(opA),  32'h0);
      applyStimulus(8'h12);
      checkOutput("f1_A",           32'(opA),  32'h1234);
      applyStimulus(8'h01);
      checkOutput("f1_B_partial",   32'(opB),  32'h0);
      applyStimulus(8'h01);
      checkOutput("f1_B",           32'(opB),  32'h0101);
      applyStimulus(8'h20);
      checkOutput("f1_OP",          32'(opCode),  32'h20);
      checkOutput("f1_start_lat0",  32'(txStart), 32'h0);
      step();
      checkOutput("f1_start_lat1",  32'(txStart), 32'h0);
      step();
      checkOutput("f1_start_b0",    32'(txStart), 32'h1);
      checkOutput("f1_data_b0",     32'(txData),  32'h35);
      step();
      checkOutput("f1_start_pulse", 32'(txStart), 32'h0);
      pulseTxDone();
      checkOutput("f1_busy_mid",    32'(busy),    32'h1);
      step();
      checkOutput("f1_start_b1",    32'(txStart), 32'h1);
      checkOutput("f1_data_b1",     32'(txData),  32'h13);
      step();
      pulseTxDone();
      checkOutput("f1_busy_end",    32'(busy),    32'h0);

      // Stray tx_done while idle must not start anything.
      pulseTxDone();
      checkOutput("idle_done_start", 32'(txStart), 32'h0);
      checkOutput("idle_done_busy",  32'(busy),    32'h0);

      // Overrun: 0x0005 + 0x0003 = 0x0008, stray 0xAA during TX_WAIT.
      sendFrame(8'h05, 8'h00, 8'h03, 8'h00, 8'h10);
      step();
      step();
      checkOutput("ovr_data_b0",  32'(txData),  32'h08);
      applyStimulus(8'hAA);
      checkOutput("ovr_pulse",    32'(overrun), 32'h1);
      step();
      checkOutput("ovr_pulse_end", 32'(overrun), 32'h0);
      checkOutput("ovr_A_kept",   32'(opA),     32'h0005);
      checkOutput("ovr_busy",     32'(busy),    32'h1);
      pulseTxDone();
      step();
      checkOutput("ovr_start_b1", 32'(txStart), 32'h1);
      checkOutput("ovr_data_b1",  32'(txData),  32'h00);
      step();
      pulseTxDone();
      checkOutput("ovr_busy_end", 32'(busy),    32'h0);

      // Asynchronous reset while waiting on the first result byte.
      sendFrame(8'h34, 8'h12, 8'h01, 8'h01, 8'h20);
      step();
      step();
      step();
      reset = 1'b0;
      #1;
      checkOutput("arst_A",     32'(opA),     32'h0);
      checkOutput("arst_B",     32'(opB),     32'h0);
      checkOutput("arst_OP",    32'(opCode),  32'h0);
      checkOutput("arst_data",  32'(txData),  32'h0);
      checkOutput("arst_busy",  32'(busy),    32'h0);
      step();
      reset = 1'b1;
      step();
      sendFrame(8'h02, 8'h00, 8'h03, 8'h00, 8'h07);
      checkOutput("post_rst_A", 32'(opA),     32'h0002);
      step();
      step();
      checkOutput("post_rst_start", 32'(txStart), 32'h1);
      checkOutput("post_rst_data",  32'(txData),  32'h05);
      step();
      pulseTxDone();
      step();
      checkOutput("post_rst_data1", 32'(txData),  32'h00);
      step();
      pulseTxDone();

      // Timeout: one byte then 50 silent cycles aborts the frame.
      applyStimulus(8'h34);
      for (int i = 0; i < 49; i++) step();
      checkOutput("to_no_err_early", 32'(frameErr), 32'h0);
      step();
      checkOutput("to_err_pulse",    32'(frameErr), 32'h1);
      checkOutput("to_busy_drop",    32'(busy),     32'h0);
      checkOutput("to_A_kept",       32'(opA),      32'h0002);
      step();
      checkOutput("to_err_once",     32'(frameErr), 32'h0);
      sendFrame(8'h11, 8'h00, 8'h22, 8'h00, 8'h01);
      checkOutput("to_next_A",  32'(opA), 32'h0011);
      checkOutput("to_next_B",  32'(opB), 32'h0022);
      step();
      step();
      checkOutput("to_next_data", 32'(txData), 32'h33);
      step();
      pulseTxDone();
      step();
      step();
      pulseTxDone();

      // Byte arriving exactly on the expiry cycle is accepted.
      applyStimulus(8'h78);
      for (int i = 0; i < 49; i++) step();
      applyStimulus(8'h56);
      checkOutput("edge_no_err", 32'(frameErr), 32'h0);
      checkOutput("edge_A",      32'(opA),      32'h5678);
      step();
      checkOutput("edge_no_err2", 32'(frameErr), 32'h0);
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      step();
      step();
      checkOutput("edge_data_b0", 32'(txData), 32'h79);
      step();
      pulseTxDone();
      step();
      checkOutput("edge_data_b1", 32'(txData), 32'h56);
      step();
      pulseTxDone();
      checkOutput("edge_busy_end", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
